source_mode_switcher: RTL and testbench

- Parametrised successor of the top-level mode selector.
- Routes one of N_SRC player sources (speaker bit, LED bar, 8-digit display nibbles) to the board outputs, chosen by a source-select index.
- Adds sequential behaviour absent before: the select is debounced, the speaker is muted for a fixed window on every switch, and all outputs are registered.
- Sits between the player blocks (auto player, keyboard, learning) and the seg_display / speaker / LED pins.

---
 rtl/source_mode_switcher.sv | 158 +++++++++++++++
 tb/tb_source_mode_switcher.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/source_mode_switcher.sv
// Debounced source selector: routes one of N_SRC player sources to the board outputs,
// muting the speaker/LEDs after each switch. Define SWITCH_BANNER_EN to show the new source number during the mute.
module source_mode_switcher #(
  parameter int          N_SRC       = 3,
  parameter int          LED_W       = 8,
  parameter int          SETTLE_CYC  = 200000,
  parameter int          MUTE_CYC    = 1000000,
  parameter logic [31:0] IDLE_DIGITS = 32'h6E770DDD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             src_sel,
  input  logic [N_SRC-1:0]       src_speaker,
  input  logic [N_SRC*LED_W-1:0] src_led,
  input  logic [N_SRC*32-1:0]    src_digits,
  output logic                   speaker,
  output logic [LED_W-1:0]       led,
  output logic [31:0]            digits,
  output logic [2:0]             active_src,
  output logic                   switching
);

  typedef enum logic [1:0] {IDLE, SETTLE, MUTE, ACTIVE} state_t;

  localparam logic [2:0] IDLE_IDX = 3'd7;
  localparam int MAXC  = (SETTLE_CYC > MUTE_CYC) ? SETTLE_CYC : MUTE_CYC;
  localparam int CNT_W = $clog2(MAXC) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MUTE_LAST   = CNT_W'(MUTE_CYC - 1);

  state_t             state_q, state_d;
  logic [2:0]         pend_q, pend_d;
  logic [2:0]         active_q, active_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               speaker_q, speaker_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [31:0]        digits_q, digits_d;

  logic [2:0]         req;
  logic               sel_spk;
  logic [LED_W-1:0]   sel_led;
  logic [31:0]        sel_dig;

  always_comb begin
    req = ({29'd0, src_sel} < 32'(N_SRC)) ? src_sel : IDLE_IDX;
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE, ACTIVE: begin
        if (req != active_q) begin
          pend_d  = req;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // Returning to the committed source cancels the switch without a mute.
        if (req == active_q) begin
          cnt_d   = '0;
          state_d = (active_q == IDLE_IDX) ? IDLE : ACTIVE;
        end else if (req != pend_q) begin
          pend_d = req;
          cnt_d  = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          active_d = pend_q;
          cnt_d    = '0;
          state_d  = (pend_q == IDLE_IDX) ? IDLE : MUTE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MUTE: begin
        if (req != active_q) begin
          pend_d  = req;
          cnt_d   = '0;
          state_d = SETTLE;
        end else if (cnt_q == MUTE_LAST) begin
          cnt_d   = '0;
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Source mux keyed on the index committed this cycle, so outputs land one cycle after inputs.
  always_comb begin
    sel_spk = 1'b0;
    sel_led = '0;
    sel_dig = IDLE_DIGITS;
    for (int i = 0; i < N_SRC; i++) begin
      if (active_d == 3'(i)) begin
        sel_spk = src_speaker[i];
        sel_led = src_led[i*LED_W +: LED_W];
        sel_dig = src_digits[i*32 +: 32];
      end
    end
  end

  always_comb begin
    speaker_d = 1'b0;
    led_d     = '0;
    digits_d  = IDLE_DIGITS;
    case (state_d)
      SETTLE: begin
        led_d    = led_q;
        digits_d = digits_q;
      end
      MUTE: begin
`ifdef SWITCH_BANNER_EN
        digits_d = {28'hDDDDDDD, 1'b0, active_d};
`else
        digits_d = sel_dig;
`endif
      end
      ACTIVE: begin
        speaker_d = sel_spk;
        led_d     = sel_led;
        digits_d  = sel_dig;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= IDLE_IDX;
      active_q  <= IDLE_IDX;
      cnt_q     <= '0;
      speaker_q <= 1'b0;
      led_q     <= '0;
      digits_q  <= IDLE_DIGITS;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      speaker_q <= speaker_d;
      led_q     <= led_d;
      digits_q  <= digits_d;
    end
  end

  assign speaker    = speaker_q;
  assign led        = led_q;
  assign digits     = digits_q;
  assign active_src = active_q;
  assign switching  = (state_q == SETTLE) || (state_q == MUTE);

endmodule

// File: tb/tb_source_mode_switcher.sv
// Directed bench for source_mode_switcher: N_SRC=3, SETTLE_CYC=4, MUTE_CYC=8.
module tb_source_mode_switcher;

  localparam logic [31:0] IDLE_DIG = 32'h6E770DDD;
`ifdef SWITCH_BANNER_EN
  localparam logic [31:0] MUTE_DIG2 = 32'hDDDDDDD2;
`else
  localparam logic [31:0] MUTE_DIG2 = 32'hA0000002;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_sel;
  logic        tog;
  logic        tog_edge;
  logic [2:0]  src_speaker;
  logic [23:0] src_led;
  logic [95:0] src_digits;
  logic        speaker;
  logic [7:0]  led;
  logic [31:0] digits;
  logic [2:0]  active_src;
  logic        switching;

  int n_chk  = 0;
  int n_fail = 0;

  assign src_speaker = {3{tog}};
  assign src_led     = {8'h33, 8'h22, 8'h11};
  assign src_digits  = {32'hA0000002, 32'hA0000001, 32'hA0000000};

  source_mode_switcher #(
    .N_SRC(3), .LED_W(8), .SETTLE_CYC(4), .MUTE_CYC(8), .IDLE_DIGITS(32'h6E770DDD)
  ) dut (
    .clk(clk), .rst(rst), .src_sel(src_sel), .src_speaker(src_speaker),
    .src_led(src_led), .src_digits(src_digits), .speaker(speaker), .led(led),
    .digits(digits), .active_src(active_src), .switching(switching)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    tog_edge = tog;
    @(posedge clk);
    #1;
    tog = ~tog;
  endtask

  initial begin
    int n, n_set, n_mute;
    rst = 1'b1; src_sel = 3'd7; tog = 1'b0; tog_edge = 1'b0;
    #12;
    check("rst_act", active_src, 7);
    check("rst_sw", switching, 0);
    check("rst_dig", digits, IDLE_DIG);
    check("rst_led", led, 0);
    @(negedge clk); rst = 1'b0;
    tick();
    check("idle_hold", active_src, 7);

    // Clean switch 7 -> 2
    src_sel = 3'd2; n_set = 0; n_mute = 0;
    tick();
    for (int k = 0; k < 40 && switching; k++) begin
      if (active_src == 3'd7) begin
        n_set++;
        check("settle_dig", digits, IDLE_DIG);
      end else begin
        n_mute++;
        check("mute_led", led, 0);
        check("mute_spk", speaker, 0);
        check("mute_dig", digits, MUTE_DIG2);
      end
      tick();
    end
    check("clean_settle", n_set, 4);
    check("clean_mute", n_mute, 8);
    check("clean_act", active_src, 2);
    check("clean_led", led, 8'h33);
    check("clean_dig", digits, 32'hA0000002);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("spk_follow", speaker, tog_edge);
      #3;
      check("spk_latency", speaker, tog_edge);
    end

    // Bounce 0,1,0,1 then hold 1
    for (int k = 0; k < 8; k++) begin
      src_sel = ((k / 2) % 2 == 1) ? 3'd1 : 3'd0;
      tick();
      check("bounce_act", active_src, 2);
      check("bounce_sw", switching, 1);
    end
    src_sel = 3'd1; n = 0;
    while (active_src != 3'd1 && n < 20) begin tick(); n++; end
    check("bounce_wait", n, 3);
    n = 0;
    while (switching && n < 20) begin tick(); n++; end
    check("bounce_mute", n, 8);
    check("bounce_led", led, 8'h22);

    // Out of range -> idle, no mute
    src_sel = 3'd5; n = 0;
    while (active_src != 3'd7 && n < 20) begin tick(); n++; end
    check("oor_wait", n, 5);
    check("oor_sw", switching, 0);
    check("oor_dig", digits, IDLE_DIG);
    check("oor_led", led, 0);

    // Abort: mute toward 1 interrupted by 0
    src_sel = 3'd1; n = 0;
    while (active_src != 3'd1 && n < 20) begin tick(); n++; end
    check("abort_commit1", n, 5);
    tick(); tick();
    check("abort_mute_led", led, 0);
    src_sel = 3'd0; n = 0;
    while (active_src != 3'd0 && n < 20) begin
      tick(); n++;
      check("abort_led0", led, 0);
    end
    check("abort_wait", n, 5);
    n = 0;
    while (switching && n < 20) begin tick(); n++; end
    check("abort_mute", n, 8);
    check("abort_led", led, 8'h11);
    check("abort_dig", digits, 32'hA0000000);

    // Brief request that returns to the committed source
    src_sel = 3'd2; tick();
    check("ret_sw1", switching, 1);
    tick();
    src_sel = 3'd0; tick();
    check("ret_sw0", switching, 0);
    check("ret_act", active_src, 0);
    check("ret_led", led, 8'h11);

    // Async reset mid-ACTIVE on source 1
    src_sel = 3'd1; n = 0;
    tick();
    while (switching && n < 40) begin tick(); n++; end
    check("pre_rst_act", active_src, 1);
    check("pre_rst_led", led, 8'h22);
    #3 rst = 1'b1;
    #1;
    check("arst_spk", speaker, 0);
    check("arst_led", led, 0);
    check("arst_dig", digits, IDLE_DIG);
    check("arst_act", active_src, 7);
    check("arst_sw", switching, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
